// File: rtl/zynq_axil_pkg.sv
// Shared AXI4-Lite definitions for the Zynq GP0 CSR path: master FSM states,
// response codes and the fixed protection attribute.
package zynq_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RSP,
        RD_REQ,
        RD_RSP,
        RESP
    } axil_state_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT = 3'b000;

endpackage

// File: rtl/axil_cmd_master.sv
// Turns a valid/ready command stream into single AXI4-Lite master transactions
// (one outstanding at a time) and returns one response per command.
module axil_cmd_master
    import zynq_axil_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 10,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                              aclk,
    input  logic                              aresetn,

    input  logic                              cmd_v_i,
    output logic                              cmd_ready_o,
    input  logic                              cmd_we_i,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_data_i,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_strb_i,

    output logic                              resp_v_o,
    input  logic                              resp_ready_i,
    output logic                              resp_we_o,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     resp_data_o,
    output logic                              resp_err_o,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,

    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,

    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;

    axil_state_e   state_q,     state_d;

    logic [AW-1:0] addr_q,      addr_d;
    logic [DW-1:0] data_q,      data_d;
    logic [SW-1:0] strb_q,      strb_d;
    logic          we_q,        we_d;

    logic          awvalid_q,   awvalid_d;
    logic          wvalid_q,    wvalid_d;
    logic          arvalid_q,   arvalid_d;
    logic          bready_q,    bready_d;
    logic          rready_q,    rready_d;
    logic          aw_done_q,   aw_done_d;
    logic          w_done_q,    w_done_d;

    logic          cmd_ready_q, cmd_ready_d;
    logic          resp_v_q,    resp_v_d;
    logic          resp_we_q,   resp_we_d;
    logic [DW-1:0] resp_data_q, resp_data_d;
    logic          resp_err_q,  resp_err_d;

    // Only bit 1 of a response code distinguishes error from success.
    logic          unused_resp_lsbs;
    assign unused_resp_lsbs = m_axi_bresp[0] ^ m_axi_rresp[0];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        strb_d      = strb_q;
        we_d        = we_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        cmd_ready_d = cmd_ready_q;
        resp_v_d    = resp_v_q;
        resp_we_d   = resp_we_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_v_i && cmd_ready_q) begin
                    addr_d      = cmd_addr_i;
                    data_d      = cmd_data_i;
                    strb_d      = cmd_strb_i;
                    we_d        = cmd_we_i;
                    cmd_ready_d = 1'b0;
                    if (cmd_we_i) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end

            // Address and data channels retire independently, in any order.
            WR_REQ: begin
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = WR_RSP;
                    bready_d = 1'b1;
                end
            end

            WR_RSP: begin
                if (bready_q && m_axi_bvalid) begin
                    bready_d    = 1'b0;
                    resp_v_d    = 1'b1;
                    resp_we_d   = we_q;
                    resp_data_d = '0;
                    resp_err_d  = m_axi_bresp[1];
                    state_d     = RESP;
                end
            end

            RD_REQ: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RSP;
                end
            end

            RD_RSP: begin
                if (rready_q && m_axi_rvalid) begin
                    rready_d    = 1'b0;
                    resp_v_d    = 1'b1;
                    resp_we_d   = we_q;
                    resp_data_d = m_axi_rdata;
                    resp_err_d  = m_axi_rresp[1];
                    state_d     = RESP;
                end
            end

            // cmd_ready is re-armed through the flop, so resp_ready never reaches it combinationally.
            RESP: begin
                if (resp_ready_i) begin
                    resp_v_d    = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                arvalid_d   = 1'b0;
                bready_d    = 1'b0;
                rready_d    = 1'b0;
                resp_v_d    = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            we_q        <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            resp_v_q    <= 1'b0;
            resp_we_q   <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            we_q        <= we_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            cmd_ready_q <= cmd_ready_d;
            resp_v_q    <= resp_v_d;
            resp_we_q   <= resp_we_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign resp_v_o      = resp_v_q;
    assign resp_we_o     = resp_we_q;
    assign resp_data_o   = resp_data_q;
    assign resp_err_o    = resp_err_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = AXI_PROT;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = data_q;
    assign m_axi_wstrb   = strb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = AXI_PROT;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

    a_aw_hold: assert property (@(posedge aclk) disable iff (!aresetn)
        m_axi_awvalid && !m_axi_awready |=> m_axi_awvalid && $stable(m_axi_awaddr));
    a_w_hold: assert property (@(posedge aclk) disable iff (!aresetn)
        m_axi_wvalid && !m_axi_wready |=> m_axi_wvalid && $stable(m_axi_wdata) && $stable(m_axi_wstrb));
    a_ar_hold: assert property (@(posedge aclk) disable iff (!aresetn)
        m_axi_arvalid && !m_axi_arready |=> m_axi_arvalid && $stable(m_axi_araddr));
    a_no_stray_b: assert property (@(posedge aclk) disable iff (!aresetn)
        m_axi_bvalid |-> state_q == WR_RSP);
    a_no_stray_r: assert property (@(posedge aclk) disable iff (!aresetn)
        m_axi_rvalid |-> state_q == RD_RSP);

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a delay-programmable AXI4-Lite slave model plus a
// reference memory that predicts every response.
module tb_axil_cmd_master;

    localparam logic [9:0] ERR_BASE = 10'h3F0;   // SLVERR below 0x3F8, DECERR above
    localparam logic [9:0] DEC_BASE = 10'h3F8;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_v_i, cmd_ready_o, cmd_we_i;
    logic [9:0]  cmd_addr_i;
    logic [31:0] cmd_data_i;
    logic [3:0]  cmd_strb_i;
    logic        resp_v_o, resp_ready_i, resp_we_o, resp_err_o;
    logic [31:0] resp_data_o;
    logic [9:0]  m_axi_awaddr, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    always #5 aclk = ~aclk;

    axil_cmd_master #(
        .C_M_AXI_ADDR_WIDTH (10),
        .C_M_AXI_DATA_WIDTH (32)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cmd_v_i       (cmd_v_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_we_i      (cmd_we_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_data_i    (cmd_data_i),
        .cmd_strb_i    (cmd_strb_i),
        .resp_v_o      (resp_v_o),
        .resp_ready_i  (resp_ready_i),
        .resp_we_o     (resp_we_o),
        .resp_data_o   (resp_data_o),
        .resp_err_o    (resp_err_o),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          hung     = 1'b0;

    logic [31:0] slave_mem [256];
    logic [31:0] ref_mem   [256];

    int unsigned aw_dly, w_dly, b_dly, ar_dly, r_dly;
    int unsigned aw_wait, w_wait, b_wait, ar_wait, r_wait;
    bit          aw_got, w_got, ar_got;
    bit          aw_hs_p, w_hs_p, b_hs_p, ar_hs_p, r_hs_p;
    logic [9:0]  last_aw_addr, last_ar_addr;
    logic [31:0] last_w_data;
    logic [3:0]  last_w_strb;
    int          n_aw, n_w, bready_early, axi_viol;
    logic        prev_awvalid, prev_wvalid, prev_arvalid;
    logic [9:0]  prev_awaddr, prev_araddr;
    logic [31:0] prev_wdata;
    logic [3:0]  prev_wstrb;

    int          last_lat;
    logic [31:0] last_resp_data;
    logic        last_resp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Slave model: evaluated on the falling edge; handshakes decided here complete
    // on the following rising edge and are retired on the next falling edge.
    initial begin
        logic [7:0] idx;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_bresp   = 2'b00; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        m_axi_rresp   = 2'b00; m_axi_rdata = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_hs_p = 0; w_hs_p = 0; b_hs_p = 0; ar_hs_p = 0; r_hs_p = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                prev_awvalid = 0; prev_wvalid = 0; prev_arvalid = 0;
            end else begin
                if (prev_awvalid && !aw_hs_p && (!m_axi_awvalid || m_axi_awaddr !== prev_awaddr))
                    axi_viol++;
                if (prev_wvalid && !w_hs_p && (!m_axi_wvalid || m_axi_wdata !== prev_wdata ||
                                               m_axi_wstrb !== prev_wstrb))
                    axi_viol++;
                if (prev_arvalid && !ar_hs_p && (!m_axi_arvalid || m_axi_araddr !== prev_araddr))
                    axi_viol++;

                if (aw_hs_p) begin m_axi_awready = 1'b0; aw_got = 1; n_aw++; end
                if (w_hs_p)  begin m_axi_wready  = 1'b0; w_got  = 1; n_w++;  end
                if (ar_hs_p) begin m_axi_arready = 1'b0; ar_got = 1; end
                if (b_hs_p) begin
                    m_axi_bvalid = 1'b0; aw_got = 0; w_got = 0;
                    aw_wait = 0; w_wait = 0; b_wait = 0;
                end
                if (r_hs_p) begin
                    m_axi_rvalid = 1'b0; ar_got = 0; ar_wait = 0; r_wait = 0;
                end
                if (m_axi_bready && !(aw_got && w_got)) bready_early++;

                if (m_axi_awvalid && !aw_got && !m_axi_awready) begin
                    if (aw_wait >= aw_dly) m_axi_awready = 1'b1; else aw_wait++;
                end
                if (m_axi_wvalid && !w_got && !m_axi_wready) begin
                    if (w_wait >= w_dly) m_axi_wready = 1'b1; else w_wait++;
                end
                if (m_axi_arvalid && !ar_got && !m_axi_arready) begin
                    if (ar_wait >= ar_dly) m_axi_arready = 1'b1; else ar_wait++;
                end
                if (aw_got && w_got && !m_axi_bvalid) begin
                    if (b_wait >= b_dly) begin
                        idx = last_aw_addr[9:2];
                        if (last_aw_addr >= ERR_BASE) begin
                            m_axi_bresp = (last_aw_addr >= DEC_BASE) ? 2'b11 : 2'b10;
                        end else begin
                            m_axi_bresp = 2'b00;
                            for (int b = 0; b < 4; b++)
                                if (last_w_strb[b]) slave_mem[idx][8*b +: 8] = last_w_data[8*b +: 8];
                        end
                        m_axi_bvalid = 1'b1;
                    end else b_wait++;
                end
                if (ar_got && !m_axi_rvalid) begin
                    if (r_wait >= r_dly) begin
                        idx = last_ar_addr[9:2];
                        m_axi_rdata  = slave_mem[idx];
                        m_axi_rresp  = (last_ar_addr >= DEC_BASE) ? 2'b11 :
                                       (last_ar_addr >= ERR_BASE) ? 2'b10 : 2'b00;
                        m_axi_rvalid = 1'b1;
                    end else r_wait++;
                end

                aw_hs_p = m_axi_awvalid && m_axi_awready;
                if (aw_hs_p) last_aw_addr = m_axi_awaddr;
                w_hs_p = m_axi_wvalid && m_axi_wready;
                if (w_hs_p) begin last_w_data = m_axi_wdata; last_w_strb = m_axi_wstrb; end
                ar_hs_p = m_axi_arvalid && m_axi_arready;
                if (ar_hs_p) last_ar_addr = m_axi_araddr;
                b_hs_p = m_axi_bvalid && m_axi_bready;
                r_hs_p = m_axi_rvalid && m_axi_rready;

                prev_awvalid = m_axi_awvalid; prev_awaddr = m_axi_awaddr;
                prev_wvalid  = m_axi_wvalid;  prev_wdata  = m_axi_wdata; prev_wstrb = m_axi_wstrb;
                prev_arvalid = m_axi_arvalid; prev_araddr = m_axi_araddr;
            end
        end
    end

    task automatic set_dly(input int unsigned aw, input int unsigned w, input int unsigned b,
                           input int unsigned ar, input int unsigned r);
        aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    // Issue one command, predict its response from the reference memory, and
    // hold resp_ready low for 'hold' cycles once the response appears.
    task automatic do_cmd(input logic we, input logic [9:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int unsigned hold);
        logic [31:0] exp_data;
        logic        exp_err;
        logic [7:0]  idx;
        bit          ok;
        idx      = addr[9:2];
        exp_err  = (addr >= ERR_BASE);
        exp_data = '0;
        if (we) begin
            if (!exp_err)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
        end else begin
            exp_data = ref_mem[idx];
        end

        cmd_we_i = we; cmd_addr_i = addr; cmd_data_i = data; cmd_strb_i = strb; cmd_v_i = 1'b1;
        ok = 0;
        for (int n = 0; n < 64; n++) begin
            if (cmd_ready_o) begin ok = 1; break; end
            @(negedge aclk);
        end
        chk("accept", 32'(ok), 1);
        if (!ok) begin cmd_v_i = 1'b0; hung = 1; return; end
        @(negedge aclk);
        cmd_v_i    = 1'b0;
        cmd_we_i   = 1'($urandom);
        cmd_addr_i = 10'($urandom);
        cmd_data_i = $urandom;
        cmd_strb_i = 4'($urandom);

        ok = 0;
        for (int n = 0; n < 256; n++) begin
            if (resp_v_o) begin ok = 1; last_lat = n; break; end
            @(negedge aclk);
        end
        chk("response", 32'(ok), 1);
        if (!ok) begin hung = 1; return; end

        for (int unsigned h = 0; h < hold; h++) begin
            chk("hold_v", resp_v_o, 1);
            chk("hold_data", resp_data_o, exp_data);
            chk("hold_err", resp_err_o, exp_err);
            chk("hold_cmd_ready", cmd_ready_o, 0);
            @(negedge aclk);
        end
        chk("resp_v", resp_v_o, 1);
        chk("resp_we", resp_we_o, we);
        chk("resp_err", resp_err_o, exp_err);
        chk("resp_data", resp_data_o, exp_data);
        if (we) begin
            chk("awaddr", last_aw_addr, addr);
            chk("wdata", last_w_data, data);
            chk("wstrb", last_w_strb, strb);
            chk("awprot", m_axi_awprot, 0);
        end else begin
            chk("araddr", last_ar_addr, addr);
            chk("arprot", m_axi_arprot, 0);
        end
        last_resp_data = resp_data_o;
        last_resp_err  = resp_err_o;

        resp_ready_i = 1'b1;
        @(negedge aclk);
        resp_ready_i = 1'b0;
        chk("resp_drop", resp_v_o, 0);
        chk("idle_ready", cmd_ready_o, 1);
    endtask

    initial begin
        logic        r_we;
        logic [7:0]  r_idx;
        logic [31:0] r_data;
        logic [3:0]  r_strb;
        logic [9:0]  a;

        cmd_v_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_data_i = '0; cmd_strb_i = '0;
        resp_ready_i = 1'b0;
        n_aw = 0; n_w = 0; bready_early = 0; axi_viol = 0;
        set_dly(0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin slave_mem[i] = '0; ref_mem[i] = '0; end

        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_awvalid", m_axi_awvalid, 0);
        chk("rst_wvalid", m_axi_wvalid, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_bready", m_axi_bready, 0);
        chk("rst_rready", m_axi_rready, 0);
        chk("rst_resp_v", resp_v_o, 0);
        chk("rst_resp_data", resp_data_o, 0);
        chk("rst_resp_err", resp_err_o, 0);
        chk("rst_resp_we", resp_we_o, 0);

        // Write then read back with a zero-wait slave: response in cycle 3 after accept.
        do_cmd(1'b1, 10'h004, 32'hDEAD_BEEF, 4'hF, 0);
        chk("t1_wr_lat", last_lat, 2);
        do_cmd(1'b0, 10'h004, 32'h0, 4'h0, 0);
        chk("t1_rd_lat", last_lat, 2);
        chk("t1_rd_data", last_resp_data, 32'hDEAD_BEEF);

        // aw late, w late, both together: one handshake each, bready after both.
        for (int m = 0; m < 3; m++) begin
            set_dly((m == 0) ? 3 : (m == 2) ? 2 : 0, (m == 1) ? 3 : (m == 2) ? 2 : 0, 1, 0, 0);
            n_aw = 0; n_w = 0; bready_early = 0;
            a = 10'(16 + 4 * m);
            do_cmd(1'b1, a, $urandom, 4'hF, 0);
            chk("t2_aw_count", n_aw, 1);
            chk("t2_w_count", n_w, 1);
            chk("t2_bready_early", bready_early, 0);
        end

        // Partial-strobe write over all-ones.
        set_dly(0, 0, 0, 0, 0);
        do_cmd(1'b1, 10'h008, 32'hFFFF_FFFF, 4'hF, 0);
        do_cmd(1'b1, 10'h008, 32'h1234_5678, 4'b0011, 0);
        do_cmd(1'b0, 10'h008, 32'h0, 4'h0, 0);
        chk("t3_rd_data", last_resp_data, 32'hFFFF_5678);
        do_cmd(1'b1, 10'h00C, 32'hCAFE_F00D, 4'h0, 0);

        // Error read with payload captured, response held for 10 cycles.
        slave_mem[8'hFD] = 32'hA5A5_5A5A;
        ref_mem[8'hFD]   = 32'hA5A5_5A5A;
        set_dly(1, 0, 0, 2, 1);
        do_cmd(1'b0, 10'h3F4, 32'h0, 4'h0, 10);
        chk("t4_err", last_resp_err, 1);
        chk("t4_data", last_resp_data, 32'hA5A5_5A5A);
        do_cmd(1'b1, 10'h3FC, 32'h1111_2222, 4'hF, 3);
        chk("t4_wr_err", last_resp_err, 1);

        // Reset while awvalid is outstanding; the write is dropped.
        set_dly(6, 0, 0, 0, 0);
        chk("t5_pre_ready", cmd_ready_o, 1);
        cmd_we_i = 1'b1; cmd_addr_i = 10'h020; cmd_data_i = 32'h7777_7777; cmd_strb_i = 4'hF;
        cmd_v_i = 1'b1;
        @(negedge aclk);
        cmd_v_i = 1'b0;
        chk("t5_awvalid", m_axi_awvalid, 1);
        chk("t5_wvalid", m_axi_wvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("t5_rst_awvalid", m_axi_awvalid, 0);
        chk("t5_rst_wvalid", m_axi_wvalid, 0);
        chk("t5_rst_arvalid", m_axi_arvalid, 0);
        chk("t5_rst_bready", m_axi_bready, 0);
        chk("t5_rst_rready", m_axi_rready, 0);
        chk("t5_rst_resp_v", resp_v_o, 0);
        chk("t5_rst_resp_err", resp_err_o, 0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("t5_idle_ready", cmd_ready_o, 1);
        chk("t5_idle_awvalid", m_axi_awvalid, 0);
        set_dly(0, 0, 0, 0, 0);
        do_cmd(1'b0, 10'h020, 32'h0, 4'h0, 0);
        chk("t5_dropped", last_resp_data, 32'h0);
        do_cmd(1'b1, 10'h020, 32'h0BAD_F00D, 4'hF, 0);
        do_cmd(1'b0, 10'h020, 32'h0, 4'h0, 0);
        chk("t5_after", last_resp_data, 32'h0BAD_F00D);

        // Random traffic over a small window plus the error region.
        for (int i = 0; i < 1000 && !hung; i++) begin
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            r_we   = 1'($urandom_range(0, 1));
            r_idx  = 8'($urandom_range(0, 19));
            if (r_idx >= 8'd16) r_idx = r_idx + 8'hEC;
            r_data = $urandom;
            r_strb = 4'($urandom);
            do_cmd(r_we, {r_idx, 2'b00}, r_data, r_strb, $urandom_range(0, 2));
        end

        chk("axi_stable", axi_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
